lsu_dccm_vec_mem: RTL

Parametrised, banked DCCM data array with a built-in vector access sequencer. It is the next-generation replacement for the fixed two-lane DCCM path: it accepts one request of up to LANES consecutive words per handshake and splits it into bank-parallel beats of at most NUM_BANKS words. It stalls on LSU freeze and returns all lanes as a single response. It sits between the LSU DC3 stage and the memory wrapper, in place of the fixed-width DCCM instance.

---
 rtl/lsu_dccm_vec_mem.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsu_dccm_vec_mem.sv
// lsu_dccm_vec_mem: banked DCCM data array with a vector access sequencer.
// One handshake carries up to LANES consecutive words. The request is split
// into conflict-free beats of NUM_BANKS words and returned as one response.
// Optional macro RV_DCCM_VEC_RSPREG_EN adds an output register stage on the
// response (rsp_valid/rsp_we/rsp_rdata one cycle later).
module lsu_dccm_vec_mem #(
   parameter int unsigned DATA_W    = 39,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned LANES     = 8,
   localparam int unsigned CNT_W    = $clog2(LANES + 1)
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic                    lsu_freeze_dc3,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [CNT_W-1:0]        req_cnt,
   input  logic [LANES*DATA_W-1:0] req_wdata,
   output logic                    rsp_valid,
   output logic                    rsp_we,
   output logic [LANES*DATA_W-1:0] rsp_rdata,
   output logic                    busy
);

   localparam int unsigned WIDX_W    = ADDR_W - 2;
   localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
   localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int unsigned ROW_W     = WIDX_W - BANK_BITS;
   localparam int unsigned ROWS      = (2 ** WIDX_W) / NUM_BANKS;
   localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t                          state_q, state_d;
   logic                            accept, issue, last_beat, rsp_pend;
   logic                            we_q, we_hold;
   logic [WIDX_W-1:0]               base_q;
   logic [CNT_W-1:0]                cnt_q, beat_q, cnt_in;
   logic [LANES-1:0][DATA_W-1:0]    wdata_q, lane_buf, rdata_hold;

   logic                            iss_en   [NUM_BANKS];
   logic [LANE_W-1:0]               iss_lane [NUM_BANKS];
   logic [WIDX_W-1:0]               iss_wi   [NUM_BANKS];
   logic [BANK_W-1:0]               iss_bank [NUM_BANKS];
   logic [ROW_W-1:0]                iss_row  [NUM_BANKS];

   logic [DATA_W-1:0]               mem [NUM_BANKS][ROWS];

   logic                            unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];

   // Lane count clamp: 0 or anything above LANES means a full-width request.
   assign cnt_in = (req_cnt == '0 || req_cnt > CNT_W'(LANES)) ? CNT_W'(LANES) : req_cnt;
   assign last_beat = ((32'(beat_q) + 32'd1) * NUM_BANKS) >= 32'(cnt_q);

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and issue/accept strobes.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && !rsp_pend) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!lsu_freeze_dc3) begin
               issue = 1'b1;
               if (last_beat) state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-bank slot of the current beat: lane, word index, bank and row.
   always_comb begin
      for (int unsigned j = 0; j < NUM_BANKS; j++) begin
         iss_en[j]   = issue && ((32'(beat_q) * NUM_BANKS + j) < 32'(cnt_q));
         iss_lane[j] = LANE_W'(32'(beat_q) * NUM_BANKS + j);
         iss_wi[j]   = base_q + WIDX_W'(32'(beat_q) * NUM_BANKS + j);
         iss_bank[j] = BANK_W'(iss_wi[j] % NUM_BANKS);
         iss_row[j]  = ROW_W'(iss_wi[j] / NUM_BANKS);
      end
   end

   // Array writes; contents are never reset.
   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < NUM_BANKS; j++) begin
         if (iss_en[j] && we_q) mem[iss_bank[j]][iss_row[j]] <= wdata_q[iss_lane[j]];
      end
   end

   // Request capture, beat counter, lane buffer fill and response hold.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         we_q       <= 1'b0;
         base_q     <= '0;
         cnt_q      <= '0;
         beat_q     <= '0;
         wdata_q    <= '0;
         lane_buf   <= '0;
         rdata_hold <= '0;
         we_hold    <= 1'b0;
      end else begin
         if (accept) begin
            we_q     <= req_we;
            base_q   <= req_addr[ADDR_W-1:2];
            cnt_q    <= cnt_in;
            wdata_q  <= req_wdata;
            lane_buf <= '0;
            beat_q   <= '0;
         end
         if (issue) begin
            beat_q <= beat_q + 1'b1;
            for (int unsigned j = 0; j < NUM_BANKS; j++) begin
               if (iss_en[j] && !we_q) lane_buf[iss_lane[j]] <= mem[iss_bank[j]][iss_row[j]];
            end
         end
         if (state_q == S_RESP) begin
            rdata_hold <= lane_buf;
            we_hold    <= we_q;
         end
      end
   end

`ifdef RV_DCCM_VEC_RSPREG_EN
   logic rsp_valid_q;

   // Registered completion pulse; blocks the next accept until it has gone.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) rsp_valid_q <= 1'b0;
      else        rsp_valid_q <= (state_q == S_RESP);
   end

   assign rsp_pend  = rsp_valid_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_we    = we_hold;
   assign rsp_rdata = rdata_hold;
   assign busy      = (state_q != S_IDLE) || rsp_valid_q;
`else
   // RESP shows the live lane buffer (last beat just landed); afterwards the held copy.
   assign rsp_pend  = 1'b0;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_we    = (state_q == S_RESP) ? we_q : we_hold;
   assign rsp_rdata = (state_q == S_RESP) ? lane_buf : rdata_hold;
   assign busy      = (state_q != S_IDLE);
`endif

   assign req_ready = (state_q == S_IDLE) && !rsp_pend;

endmodule
